// File: rtl/arbiter_rr_fsm_if.sv
// Request/grant bundle between requesters and the N-way arbiter.
//   req         - request vector, bit i = requester i
//   mode        - 0 fixed priority, 1 round-robin
//   grant       - registered one-hot grant
//   grant_valid - any grant bit set
//   grant_id    - index of granted requester (0 when idle)
//   timeout     - one-cycle pulse on forced release
// Modports: master = requester side, slave = arbiter side.
interface arbiter_rr_fsm_if #(
    parameter int unsigned N   = 4,
    parameter int unsigned IDW = $clog2(N)
);
    logic [N-1:0]   req;
    logic           mode;
    logic [N-1:0]   grant;
    logic           grant_valid;
    logic [IDW-1:0] grant_id;
    logic           timeout;

    modport master (
        output req,
        output mode,
        input  grant,
        input  grant_valid,
        input  grant_id,
        input  timeout
    );

    modport slave (
        input  req,
        input  mode,
        output grant,
        output grant_valid,
        output grant_id,
        output timeout
    );
endinterface

// File: rtl/arbiter_rr_fsm.sv
// N-way request arbiter with runtime fixed-priority / round-robin selection.
// A grant is issued from IDLE, held while the winner keeps requesting, and
// always followed by at least one idle cycle before the next grant.
// Ports:
//   clock   - system clock, rising edge
//   reset_n - asynchronous active-low reset
//   arb     - arbiter_rr_fsm_if.slave (req, mode in; grant, grant_valid,
//             grant_id, timeout out; all outputs registered)
// Optional feature macro: ARB_TIMEOUT_EN
//   defined   - grant is force-released after MAX_HOLD cycles, timeout pulses
//   undefined - grant held indefinitely, timeout tied to 0
module arbiter_rr_fsm #(
    parameter int unsigned N        = 4,
    parameter int unsigned IDW      = $clog2(N),
    parameter int unsigned MAX_HOLD = 16
) (
    input  logic             clock,
    input  logic             reset_n,
    arbiter_rr_fsm_if.slave  arb
);

    // Elaboration-time parameter sanity check.
    if (N < 2 || N > 16 || MAX_HOLD < 1) begin : g_param_check
        $error("arbiter_rr_fsm: N must be 2..16 and MAX_HOLD >= 1");
    end

    typedef enum logic {
        ST_IDLE  = 1'b0,
        ST_GRANT = 1'b1
    } state_e;

    // Lowest set index of r (0 when r is empty; caller gates on |r).
    function automatic logic [IDW-1:0] pick_fixed(input logic [N-1:0] r);
        logic [IDW-1:0] w;
        w = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            if (r[IDW'(i)]) w = IDW'(i);
        end
        return w;
    endfunction

    // First set index at or above ptr, wrapping N-1 -> 0. Scanning offsets
    // from high to low lets the smallest offset overwrite last.
    function automatic logic [IDW-1:0] pick_rr(input logic [N-1:0]   r,
                                               input logic [IDW-1:0] ptr);
        logic [IDW-1:0] w;
        int             idx;
        w = '0;
        for (int i = int'(N) - 1; i >= 0; i--) begin
            idx = (int'(ptr) + i) % int'(N);
            if (r[IDW'(idx)]) w = IDW'(idx);
        end
        return w;
    endfunction

    state_e         state_q,       state_d;
    logic [N-1:0]   grant_q,       grant_d;
    logic           grant_valid_q, grant_valid_d;
    logic [IDW-1:0] grant_id_q,    grant_id_d;
    logic [IDW-1:0] rr_ptr_q,      rr_ptr_d;
    logic [IDW-1:0] win_c;

`ifdef ARB_TIMEOUT_EN
    localparam int unsigned HCW = (MAX_HOLD > 1) ? $clog2(MAX_HOLD) : 1;
    logic [HCW-1:0] hold_cnt_q, hold_cnt_d;
    logic           timeout_q,  timeout_d;
`endif

    // State and output registers.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q       <= ST_IDLE;
            grant_q       <= '0;
            grant_valid_q <= 1'b0;
            grant_id_q    <= '0;
            rr_ptr_q      <= '0;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= '0;
            timeout_q     <= 1'b0;
`endif
        end else begin
            state_q       <= state_d;
            grant_q       <= grant_d;
            grant_valid_q <= grant_valid_d;
            grant_id_q    <= grant_id_d;
            rr_ptr_q      <= rr_ptr_d;
`ifdef ARB_TIMEOUT_EN
            hold_cnt_q    <= hold_cnt_d;
            timeout_q     <= timeout_d;
`endif
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_d       = state_q;
        grant_d       = grant_q;
        grant_valid_d = grant_valid_q;
        grant_id_d    = grant_id_q;
        rr_ptr_d      = rr_ptr_q;
        win_c         = arb.mode ? pick_rr(arb.req, rr_ptr_q) : pick_fixed(arb.req);
`ifdef ARB_TIMEOUT_EN
        hold_cnt_d    = hold_cnt_q;
        timeout_d     = 1'b0;
`endif

        case (state_q)
            ST_IDLE: begin
                if (|arb.req) begin
                    state_d       = ST_GRANT;
                    grant_d       = N'(1) << win_c;
                    grant_valid_d = 1'b1;
                    grant_id_d    = win_c;
                    // Pointer advances in both modes so a switch to
                    // round-robin continues after the last winner.
                    rr_ptr_d      = (win_c == IDW'(N - 1)) ? '0 : win_c + IDW'(1);
`ifdef ARB_TIMEOUT_EN
                    hold_cnt_d    = '0;
`endif
                end
            end
            ST_GRANT: begin
                if (!arb.req[grant_id_q]) begin
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                end
`ifdef ARB_TIMEOUT_EN
                else if (hold_cnt_q == HCW'(MAX_HOLD - 1)) begin
                    // Forced release; requester must re-arbitrate from IDLE.
                    state_d       = ST_IDLE;
                    grant_d       = '0;
                    grant_valid_d = 1'b0;
                    grant_id_d    = '0;
                    timeout_d     = 1'b1;
                end else begin
                    hold_cnt_d    = hold_cnt_q + HCW'(1);
                end
`endif
            end
        endcase
    end

    assign arb.grant       = grant_q;
    assign arb.grant_valid = grant_valid_q;
    assign arb.grant_id    = grant_id_q;
`ifdef ARB_TIMEOUT_EN
    assign arb.timeout     = timeout_q;
`else
    assign arb.timeout     = 1'b0;
`endif

endmodule
